data_mem: RTL and testbench
===========================

// Module: data_mem
// PURPOSE
// - Data-memory responder at the far end of the control unit's DM interface (WEdm/WriteDMadd/WriteDMdata/readDMadd -> ReadDM).
// - Word-organised RAM supporting word, half and byte stores, and loads with zero or sign extension.
// - After reset it runs a self-clearing sweep that zeroes every word, one per cycle, and reports busy while sweeping.
// - Flags misaligned accesses. Sits beside grf and alu in the single-cycle datapath.
// PARAMETERS
// - DEPTH_LOG2  10  log2 of word count (default 1024 words = 4 KiB).
// PORTS
// - clk          in   1   rising-edge clock
// - reset        in   1   asynchronous, active-low reset
// - WEdm         in   1   store enable, sampled at posedge clk
// - REdm         in   1   load qualifier, used only for alignment checking
// - DMop         in   3   access type: 000 word, 001 half-unsigned, 010 half-signed, 011 byte-unsigned, 100 byte-signed; 101-111 treated as word
// - WriteDMadd   in   32  store byte address
// - WriteDMdata  in   32  store data; low half or low byte used for half/byte stores
// - readDMadd    in   32  load byte address
// - ReadDM       out  32  load data, combinational
// - busy         out  1   high during reset and the clear sweep
// - align_err    out  1   registered one-cycle pulse on a misaligned access
// BEHAVIOUR
// - Reset (reset=0): state=CLEAR, clear counter=0, busy=1, align_err=0. Array contents are undefined until the sweep finishes.
// - FSM states CLEAR and IDLE.
//   - CLEAR: each posedge writes word[cnt]=0 and increments cnt. When cnt==DEPTH-1, the FSM moves to IDLE on that same edge.
//   - The sweep takes exactly 2^DEPTH_LOG2 cycles after reset is released. busy drops on the edge that clears the last word.
//   - IDLE is terminal until the next reset.
//   - A reset asserted mid-sweep restarts the sweep from cnt=0.
// - Address mapping:
//   - Word index = addr[DEPTH_LOG2+1:2]. Upper bits are ignored, so addresses wrap modulo 4*DEPTH.
//   - Little-endian: byte lane = addr[1:0], half lane = addr[1].
// - Alignment rules:
//   - Word access needs addr[1:0]==0. Half access needs addr[0]==0. Byte access is always aligned.
// - Stores, at posedge clk when WEdm=1 and busy=0:
//   - Word: the full word is written.
//   - Half: only the 2 selected bytes are written.
//   - Byte: only the selected byte is written. Other bytes are preserved.
//   - Signed and unsigned store types behave identically.
//   - A misaligned store is suppressed: memory is unchanged and align_err=1 on the next cycle.
//   - WEdm while busy=1 is ignored, and align_err is not raised.
// - Loads (combinational from readDMadd and DMop):
//   - Word: the full word is returned.
//   - Half/byte: the selected lane is zero- or sign-extended to 32 bits per DMop.
//   - ReadDM=0 while busy=1.
//   - ReadDM=0 when the load is misaligned. If REdm=1 at that edge, align_err=1 on the next cycle.
// - align_err timing: it is the OR of the store and load error conditions sampled at an edge. It is held high for exactly one cycle per offending edge.
// - Simultaneous load and store to the same word in one cycle: ReadDM shows the old data during that cycle and the new data after the edge. There is no bypass.
// TESTING
// - Clear sweep: release reset, count cycles with DEPTH_LOG2=4 -> busy high for exactly 16 cycles, then 0. Every lw returns 0x00000000.
// - Word store/load: sw 0x12345678 to 0x00000010, then lw 0x10 -> 0x12345678. lw 0x00001010 (wrap, DEPTH=1024) -> 0x12345678.
// - Byte/half: sw 0 to 0x20, then sb 0xAB to 0x22 -> lw 0x20 gives 0x00AB0000, lb 0x22 gives 0xFFFFFFAB, lbu 0x22 gives 0x000000AB.
// - Half signed: sh 0x8001 to 0x32 -> lh 0x32 gives 0xFFFF8001, lhu 0x32 gives 0x00008001, lw 0x30 gives 0x80010000.
// - Misaligned: sw to 0x41 -> word 0x40 unchanged, align_err pulses for 1 cycle. lh with REdm=1 at 0x43 -> ReadDM=0, align_err pulses.
// - Reset/busy corners: assert reset at sweep cycle 5 -> the sweep restarts and busy lasts a full 2^DEPTH_LOG2 cycles after release. WEdm during busy -> no write and no align_err.

Source files
------------

// File: rtl/data_mem.sv
// data_mem: word-organised data RAM for the single-cycle datapath.
//   Supports word/half/byte stores and zero/sign-extended loads. After reset it
//   zeroes every word (one per cycle) and holds busy high until the sweep ends.
//   Misaligned accesses are suppressed and flagged with a one-cycle align_err pulse.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   WEdm        store enable
//   REdm        load qualifier (alignment checking only)
//   DMop        000 word, 001 hu, 010 h, 011 bu, 100 b, 101-111 word
//   WriteDMadd  store byte address
//   WriteDMdata store data (low half/byte for half/byte stores)
//   readDMadd   load byte address
//   ReadDM      combinational load data
//   busy        high during reset and the clear sweep
//   align_err   registered one-cycle misalignment pulse
//
// state | meaning
// CLEAR | zeroing word[cnt] each cycle, busy=1
// IDLE  | normal operation, terminal until reset
module data_mem #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WEdm,
  input  logic        REdm,
  input  logic [2:0]  DMop,
  input  logic [31:0] WriteDMadd,
  input  logic [31:0] WriteDMdata,
  input  logic [31:0] readDMadd,
  output logic [31:0] ReadDM,
  output logic        busy,
  output logic        align_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  logic [0:0]            state;
  logic [DEPTH_LOG2-1:0] cnt;
  logic [31:0]           mem [DEPTH];

  logic                  is_half;
  logic                  is_byte;
  logic                  is_signed;
  logic                  st_mis;
  logic                  ld_mis;
  logic                  store_go;
  logic [3:0]            be;
  logic [31:0]           wdat;
  logic [DEPTH_LOG2-1:0] widx;
  logic [DEPTH_LOG2-1:0] ridx;
  logic [31:0]           rword;
  logic [15:0]           rhalf;
  logic [7:0]            rbyte;

  // Address bits above the word index are ignored, so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^{WriteDMadd[31:DEPTH_LOG2+2], readDMadd[31:DEPTH_LOG2+2]};

  assign busy      = (state == CLEAR);
  assign is_half   = (DMop == 3'b001) || (DMop == 3'b010);
  assign is_byte   = (DMop == 3'b011) || (DMop == 3'b100);
  assign is_signed = (DMop == 3'b010) || (DMop == 3'b100);

  assign st_mis = is_byte ? 1'b0 : (is_half ? WriteDMadd[0] : |WriteDMadd[1:0]);
  assign ld_mis = is_byte ? 1'b0 : (is_half ? readDMadd[0]  : |readDMadd[1:0]);

  assign widx     = WriteDMadd[DEPTH_LOG2+1:2];
  assign ridx     = readDMadd[DEPTH_LOG2+1:2];
  assign store_go = WEdm && !busy && !st_mis;

  // Replicate the store data across all lanes; byte enables pick the lane.
  always_comb begin
    be   = 4'b1111;
    wdat = WriteDMdata;
    if (is_byte) begin
      be                   = 4'b0000;
      be[WriteDMadd[1:0]]  = 1'b1;
      wdat                 = {4{WriteDMdata[7:0]}};
    end else if (is_half) begin
      be   = WriteDMadd[1] ? 4'b1100 : 4'b0011;
      wdat = {2{WriteDMdata[15:0]}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CLEAR;
      cnt       <= '0;
      align_err <= 1'b0;
    end else begin
      align_err <= !busy && ((WEdm && st_mis) || (REdm && ld_mis));
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == '1) state <= IDLE;
      end
    end
  end

  // Array has no reset; the sweep provides the defined contents.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else if (store_go) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  assign rword = mem[ridx];
  assign rhalf = readDMadd[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (readDMadd[1:0])
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
  end

  always_comb begin
    ReadDM = '0;
    if (!busy && !ld_mis) begin
      if (is_byte)
        ReadDM = {{24{is_signed & rbyte[7]}}, rbyte};
      else if (is_half)
        ReadDM = {{16{is_signed & rhalf[15]}}, rhalf};
      else
        ReadDM = rword;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        reset;
  logic        WEdm;
  logic        REdm;
  logic [2:0]  DMop;
  logic [31:0] WriteDMadd;
  logic [31:0] WriteDMdata;
  logic [31:0] readDMadd;
  logic [31:0] ReadDM;
  logic        busy;
  logic        align_err;

  data_mem #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .WEdm(WEdm), .REdm(REdm), .DMop(DMop),
    .WriteDMadd(WriteDMadd), .WriteDMdata(WriteDMdata), .readDMadd(readDMadd),
    .ReadDM(ReadDM), .busy(busy), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        bsy;
    logic        ae;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [31:0] mem_m [DEPTH];
  int          sweep_left;
  bit          prev_err;

  // 0 word, 1 half unsigned, 2 half signed, 3 byte unsigned, 4 byte signed
  function automatic int kind(input logic [2:0] op);
    if (op >= 3'd1 && op <= 3'd4) return int'(op);
    return 0;
  endfunction

  function automatic bit mis(input logic [2:0] op, input logic [31:0] a);
    int k = kind(op);
    if (k == 0) return (a % 4) != 0;
    if (k <= 2) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] v;
    int k = kind(op);
    w = mem_m[(a / 4) % DEPTH];
    v = w >> (8 * (a % 4));
    case (k)
      1:       return v & 32'h0000FFFF;
      2:       return {{16{v[15]}}, v[15:0]};
      3:       return v & 32'h000000FF;
      4:       return {{24{v[7]}}, v[7:0]};
      default: return w;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int          k = kind(op);
    int          idx = (a / 4) % DEPTH;
    logic [31:0] mask;
    int          sh = 8 * (a % 4);
    if (k == 0) mask = 32'hFFFFFFFF;
    else if (k <= 2) mask = 32'h0000FFFF;
    else mask = 32'h000000FF;
    mem_m[idx] = (mem_m[idx] & ~(mask << sh)) | ((d & mask) << sh);
  endtask

  // Drives one cycle of inputs, queues what the DUT must show this cycle,
  // then advances the reference model across the coming edge.
  task automatic cycle(input string name, input logic rst, input logic we, input logic re,
                       input logic [2:0] op, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [31:0] ra);
    exp_t e;
    bit   b;
    reset = rst; WEdm = we; REdm = re; DMop = op;
    WriteDMadd = wa; WriteDMdata = wd; readDMadd = ra;
    e.name = name;
    if (!rst) begin
      e.bsy = 1'b1; e.rd = '0; e.ae = 1'b0;
      sweep_left = DEPTH;
      prev_err   = 1'b0;
    end else begin
      b     = (sweep_left > 0);
      e.bsy = b;
      e.ae  = prev_err;
      e.rd  = (b || mis(op, ra)) ? 32'h0 : model_load(op, ra);
      prev_err = !b && ((we && mis(op, wa)) || (re && mis(op, ra)));
      if (!b && we && !mis(op, wa)) model_store(op, wa, wd);
      if (b) begin
        sweep_left--;
        if (sweep_left == 0) foreach (mem_m[i]) mem_m[i] = '0;
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(); cycle("idle", 1, 0, 0, 3'd0, 0, 0, 0); endtask
  task automatic st(input string n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    cycle(n, 1, 1, 0, op, a, d, 0);
  endtask
  task automatic ld(input string n, input logic [2:0] op, input logic [31:0] a);
    cycle(n, 1, 0, 1, op, 0, 0, a);
  endtask

  task automatic rand_cycle(input string n, input bit allow_re);
    logic [31:0] wa;
    logic [31:0] ra;
    wa = $urandom_range(0, 127);
    ra = $urandom_range(0, 127);
    if ($urandom_range(0, 3) == 0) wa = wa | ($urandom & 32'hFFFF0000);
    if ($urandom_range(0, 3) == 0) ra = ra | ($urandom & 32'hFFFF0000);
    cycle(n, 1, 1'($urandom_range(0, 1)), allow_re ? 1'($urandom_range(0, 1)) : 1'b0,
          3'($urandom_range(0, 7)), wa, $urandom, ra);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (ReadDM === e.rd) n_pass++;
      else $display("FAIL %s ReadDM: got %h want %h at %0t", e.name, ReadDM, e.rd, $time);
      n_chk++;
      if (busy === e.bsy) n_pass++;
      else $display("FAIL %s busy: got %b want %b at %0t", e.name, busy, e.bsy, $time);
      n_chk++;
      if (align_err === e.ae) n_pass++;
      else $display("FAIL %s align_err: got %b want %b at %0t", e.name, align_err, e.ae, $time);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; WEdm = 1'b0; REdm = 1'b0; DMop = 3'd0;
    WriteDMadd = '0; WriteDMdata = '0; readDMadd = '0;
    sweep_left = DEPTH; prev_err = 1'b0;
    foreach (mem_m[i]) mem_m[i] = '0;
    @(posedge clk);
    #1;

    repeat (3) cycle("reset", 0, 0, 0, 3'd0, 0, 0, 0);

    // sweep: stores (including misaligned) while busy must be ignored
    for (int i = 0; i < DEPTH; i++) begin
      if (i % 2 == 0) cycle("busy_store", 1, 1, 0, 3'd0, 32'h41, 32'hDEADBEEF, 0);
      else            cycle("busy_store", 1, 1, 0, 3'd0, 32'(4 * i), 32'hFFFFFFFF, 32'(4 * i));
    end
    for (int i = 0; i < DEPTH; i++) ld("lw_zero", 3'd0, 32'(4 * i));

    st("sw", 3'd0, 32'h10, 32'h12345678);
    ld("lw_10", 3'd0, 32'h10);
    ld("lw_wrap", 3'd0, 32'h1010);

    st("sw0", 3'd0, 32'h20, 32'h0);
    st("sb", 3'd3, 32'h22, 32'h000000AB);
    ld("lw_20", 3'd0, 32'h20);
    ld("lb_22", 3'd4, 32'h22);
    ld("lbu_22", 3'd3, 32'h22);

    st("sw0", 3'd0, 32'h30, 32'h0);
    st("sh", 3'd2, 32'h32, 32'h00008001);
    ld("lh_32", 3'd2, 32'h32);
    ld("lhu_32", 3'd1, 32'h32);
    ld("lw_30", 3'd0, 32'h30);

    st("sw_40", 3'd0, 32'h40, 32'hCAFEF00D);
    st("sw_mis", 3'd0, 32'h41, 32'h11111111);
    idle();
    ld("lw_40", 3'd0, 32'h40);
    ld("lh_mis", 3'd2, 32'h43);
    idle();
    idle();

    // store and load to the same word: old data this cycle, new data after
    cycle("same_word", 1, 1, 1, 3'd0, 32'h14, 32'hA5A5A5A5, 32'h14);
    ld("lw_after", 3'd0, 32'h14);
    st("op7_word", 3'd7, 32'h18, 32'h89ABCDEF);
    ld("op5_word", 3'd5, 32'h18);

    repeat (300) rand_cycle("rand", 1'b1);

    // reset asserted in the middle of a sweep
    repeat (2) cycle("reset2", 0, 0, 0, 3'd0, 0, 0, 0);
    repeat (5) rand_cycle("sweep5", 1'b0);
    repeat (2) cycle("reset3", 0, 0, 0, 3'd0, 0, 0, 0);
    repeat (DEPTH) rand_cycle("resweep", 1'b0);
    for (int i = 0; i < DEPTH; i++) ld("lw_zero2", 3'd0, 32'(4 * i));

    repeat (150) rand_cycle("rand2", 1'b1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
